// File: rtl/vga_clk_gen.sv
// -----------------------------------------------------------------------------
// vga_clk_gen
//
// Fractional-N pixel-rate generator. A phase accumulator of ACC_W bits is
// advanced by a per-mode increment every fabric clock. Each carry out of the
// accumulator becomes a registered one-cycle pixel strobe. The average strobe
// rate is therefore inc / 2^ACC_W of clk_i. The VGA timing logic downstream
// qualifies everything with pix_stb_o instead of running on a derived clock.
//
// The rate can be changed at runtime without glitches. When the rate changes,
// the pixel period already in progress is allowed to finish (DRAIN), so its
// final strobe is still emitted. The strobe is then held off for a settle
// window (SETTLE) before the new rate starts (RUN). ready_o is high only in
// RUN, much like a PLL lock indicator.
//
// Parameters:
//   ACC_W         accumulator width
//   NUM_MODES     number of selectable rates (>= 1)
//   INC_TABLE     packed increments, mode m in bits [m*ACC_W +: ACC_W];
//                 an increment of 0 disables the strobe for that mode
//   SETTLE_CYCLES strobe-suppressed cycles after reset / mode change (>= 1)
//   MODE_W        mode index width
//
// Ports:
//   clk_i       fabric clock, all logic on the rising edge
//   rst_ni      asynchronous active-low reset
//   mode_i      requested mode, sampled when mode_req_i is high
//   mode_req_i  one-cycle mode change request
//   pix_stb_o   pixel-enable strobe, one cycle wide
//   mode_o      mode currently applied (updates on entry to SETTLE)
//   ready_o     high only while running at the applied rate
//   err_o       one-cycle pulse after a request with mode_i >= NUM_MODES
// -----------------------------------------------------------------------------
module vga_clk_gen #(
    parameter int                         ACC_W         = 16,
    parameter int                         NUM_MODES     = 4,
    parameter logic [NUM_MODES*ACC_W-1:0] INC_TABLE     = {16'd0, 16'd21845,
                                                           16'd16384, 16'd32768},
    parameter int                         SETTLE_CYCLES = 16,
    parameter int                         MODE_W        = (NUM_MODES > 1) ?
                                                          $clog2(NUM_MODES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              mode_req_i,
    output logic              pix_stb_o,
    output logic [MODE_W-1:0] mode_o,
    output logic              ready_o,
    output logic              err_o
);

    localparam int                CNT_W         = (SETTLE_CYCLES > 1) ?
                                                  $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD    = CNT_W'(SETTLE_CYCLES - 1);
    // One extra bit so that an index equal to NUM_MODES can be represented
    // even when NUM_MODES is a power of two.
    localparam logic [MODE_W:0]   NUM_MODES_EXT = (MODE_W + 1)'(NUM_MODES);

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               stb_q, stb_d;
    logic               err_q, err_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic               pend_v_q, pend_v_d;
    logic [MODE_W-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ACC_W-1:0]   inc_cur;
    logic [ACC_W:0]     sum;
    logic               req_valid;
    logic               req_invalid;

    // Classify the incoming request. Out-of-range indices only raise err_o and
    // never reach the pending register.
    always_comb begin
        req_valid   = 1'b0;
        req_invalid = 1'b0;
        if (mode_req_i) begin
            if ({1'b0, mode_i} < NUM_MODES_EXT) begin
                req_valid = 1'b1;
            end else begin
                req_invalid = 1'b1;
            end
        end
    end

    // Increment of the applied mode. mode_q only ever holds a valid index, so
    // the zero default is reached only when no table entry matches.
    always_comb begin
        inc_cur = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (mode_q == MODE_W'(m)) begin
                inc_cur = INC_TABLE[m*ACC_W +: ACC_W];
            end
        end
    end

    // The top bit of the widened sum is the carry that becomes the strobe.
    // Dropping it gives the modular wrap of the accumulator.
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, inc_cur};
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        stb_d    = 1'b0;
        err_d    = req_invalid;
        mode_d   = mode_q;
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;

        // Outside RUN, a valid request simply replaces the pending mode, so
        // the last request wins. A request in the same cycle as a decision
        // below is already taken into account.
        if (req_valid && (state_q != ST_RUN)) begin
            pend_v_d = 1'b1;
            pend_d   = mode_i;
        end

        case (state_q)
            ST_SETTLE: begin
                acc_d = '0;
                if (cnt_q == '0) begin
                    if (pend_v_d && (pend_d != mode_q)) begin
                        // A different rate was asked for while settling:
                        // apply it and run a fresh settle window.
                        mode_d   = pend_d;
                        pend_v_d = 1'b0;
                        cnt_d    = CNT_RELOAD;
                    end else begin
                        state_d  = ST_RUN;
                        pend_v_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RUN: begin
                acc_d = sum[ACC_W-1:0];
                stb_d = sum[ACC_W];
                if (req_valid && (mode_i != mode_q)) begin
                    if (inc_cur == '0) begin
                        // No pixel period is in progress, so there is
                        // nothing to drain.
                        state_d  = ST_SETTLE;
                        mode_d   = mode_i;
                        pend_v_d = 1'b0;
                        cnt_d    = CNT_RELOAD;
                        acc_d    = '0;
                        stb_d    = 1'b0;
                    end else begin
                        state_d  = ST_DRAIN;
                        pend_v_d = 1'b1;
                        pend_d   = mode_i;
                    end
                end
            end

            ST_DRAIN: begin
                if (stb_q) begin
                    // The strobe that closes the old period is on the output
                    // in this cycle. Leave DRAIN here so that SETTLE never
                    // shows a strobe.
                    state_d  = ST_SETTLE;
                    mode_d   = pend_d;
                    pend_v_d = 1'b0;
                    cnt_d    = CNT_RELOAD;
                    acc_d    = '0;
                    stb_d    = 1'b0;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                    stb_d = sum[ACC_W];
                end
            end

            default: begin
                state_d  = ST_SETTLE;
                acc_d    = '0;
                pend_v_d = 1'b0;
                cnt_d    = CNT_RELOAD;
            end
        endcase
    end

    // State register. Reset lands in SETTLE, so leaving reset always gives a
    // full settle window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_SETTLE;
            acc_q    <= '0;
            stb_q    <= 1'b0;
            err_q    <= 1'b0;
            mode_q   <= '0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            cnt_q    <= CNT_RELOAD;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            stb_q    <= stb_d;
            err_q    <= err_d;
            mode_q   <= mode_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    // ready_o is decoded straight from the state flop, so it drops in the
    // same instant as reset asserts.
    assign pix_stb_o = stb_q;
    assign mode_o    = mode_q;
    assign ready_o   = (state_q == ST_RUN);
    assign err_o     = err_q;

endmodule

// File: tb/tb_vga_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_clk_gen
//
// Bench for vga_clk_gen, built from two instances:
//   dut    ACC_W=8, three modes (inc 128, 64, 85), SETTLE_CYCLES=8.
//          A cycle model pushes expected outputs into a queue, and a negedge
//          monitor pops and compares them. Per-scenario tasks add direct
//          checks on counts, spacing and latencies.
//   dut_z  ACC_W=8, two modes (inc 0, 128). Used for the zero-increment
//          behaviour.
// -----------------------------------------------------------------------------
module tb_vga_clk_gen;

    localparam int ACC_W     = 8;
    localparam int NUM_MODES = 3;
    localparam int MODE_W    = 2;
    localparam int SETTLE    = 8;
    localparam logic [NUM_MODES*ACC_W-1:0] TABLE = {8'd85, 8'd64, 8'd128};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              req;
    logic [MODE_W-1:0] mode_in;
    logic              stb, rdy, err;
    logic [MODE_W-1:0] mode_out;

    logic rst_z_n, req_z, mode_z_in;
    logic stb_z, rdy_z, err_z, mode_z_out;

    vga_clk_gen #(
        .ACC_W(ACC_W), .NUM_MODES(NUM_MODES), .INC_TABLE(TABLE),
        .SETTLE_CYCLES(SETTLE), .MODE_W(MODE_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode_in), .mode_req_i(req),
        .pix_stb_o(stb), .mode_o(mode_out), .ready_o(rdy), .err_o(err)
    );

    vga_clk_gen #(
        .ACC_W(8), .NUM_MODES(2), .INC_TABLE({8'd128, 8'd0}),
        .SETTLE_CYCLES(SETTLE), .MODE_W(1)
    ) dut_z (
        .clk_i(clk), .rst_ni(rst_z_n), .mode_i(mode_z_in), .mode_req_i(req_z),
        .pix_stb_o(stb_z), .mode_o(mode_z_out), .ready_o(rdy_z), .err_o(err_z)
    );

    typedef struct packed {
        logic       stb;
        logic       rdy;
        logic [1:0] mode;
        logic       err;
    } sample_t;

    sample_t sb_q[$];
    int errors = 0;
    int checks = 0;

    // Model state: 0 = settle, 1 = run, 2 = drain.
    int m_state, m_phase, m_left, m_mode, m_pend;
    bit m_stb, m_err, m_pv;
    bit cur_req;
    int cur_mode;

    logic       o_stb, o_rdy, o_err;
    logic [1:0] o_mode;

    function automatic int inc_of(input int m);
        case (m)
            0:       return 128;
            1:       return 64;
            2:       return 85;
            default: return 0;
        endcase
    endfunction

    // Carry on the p-th accumulation since RUN entry, from the exact phase p*inc.
    function automatic bit carry(input int p, input int inc);
        return ((p * inc) >> ACC_W) != (((p - 1) * inc) >> ACC_W);
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_left   = SETTLE;
        m_phase  = 0;
        m_mode   = 0;
        m_pend   = 0;
        m_stb    = 1'b0;
        m_err    = 1'b0;
        m_pv     = 1'b0;
        cur_req  = 1'b0;
        cur_mode = 0;
    endtask

    task automatic model_advance();
        bit valid, bad;
        valid = cur_req && (cur_mode < NUM_MODES);
        bad   = cur_req && (cur_mode >= NUM_MODES);
        m_err = bad;
        case (m_state)
            0: begin
                if (valid) begin
                    m_pend = cur_mode;
                    m_pv   = 1'b1;
                end
                m_stb = 1'b0;
                if (m_left == 1) begin
                    if (m_pv && (m_pend != m_mode)) begin
                        m_mode = m_pend;
                        m_pv   = 1'b0;
                        m_left = SETTLE;
                    end else begin
                        m_state = 1;
                        m_phase = 0;
                        m_pv    = 1'b0;
                    end
                end else begin
                    m_left--;
                end
            end
            1: begin
                m_phase++;
                m_stb = carry(m_phase, inc_of(m_mode));
                if (valid && (cur_mode != m_mode)) begin
                    if (inc_of(m_mode) == 0) begin
                        m_state = 0;
                        m_mode  = cur_mode;
                        m_left  = SETTLE;
                        m_stb   = 1'b0;
                    end else begin
                        m_state = 2;
                        m_pend  = cur_mode;
                        m_pv    = 1'b1;
                    end
                end
            end
            default: begin
                if (valid) begin
                    m_pend = cur_mode;
                    m_pv   = 1'b1;
                end
                if (m_stb) begin
                    m_state = 0;
                    m_mode  = m_pend;
                    m_pv    = 1'b0;
                    m_left  = SETTLE;
                    m_stb   = 1'b0;
                end else begin
                    m_phase++;
                    m_stb = carry(m_phase, inc_of(m_mode));
                end
            end
        endcase
    endtask

    // One clock of stimulus. The model sees the same edge as the DUT, then its
    // prediction for this cycle goes into the scoreboard. The new inputs are
    // applied for the next edge.
    task automatic drive(input bit r, input int m);
        sample_t s;
        @(posedge clk);
        model_advance();
        #1;
        s.stb  = m_stb;
        s.rdy  = (m_state == 1);
        s.mode = 2'(m_mode);
        s.err  = m_err;
        sb_q.push_back(s);
        o_stb    = stb;
        o_rdy    = rdy;
        o_err    = err;
        o_mode   = mode_out;
        req      = r;
        mode_in  = 2'(m);
        cur_req  = r;
        cur_mode = m;
    endtask

    always @(negedge clk) begin
        sample_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({stb, rdy, mode_out, err} !== e) begin
                errors++;
                $display("[TB] FAIL sb_sample t=%0t got stb=%b rdy=%b mode=%0d err=%b want stb=%b rdy=%b mode=%0d err=%b",
                         $time, stb, rdy, mode_out, err, e.stb, e.rdy, e.mode, e.err);
            end
        end
    end

    task automatic test_reset();
        int low;
        bit seen;
        int cnt, adj;
        logic prev;
        rst_n   = 1'b0;
        req     = 1'b0;
        mode_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({stb, rdy, err, mode_out} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got stb=%b rdy=%b err=%b mode=%0d want all 0",
                     stb, rdy, err, mode_out);
        end
        rst_n = 1'b1;
        model_reset();
        low  = (rdy === 1'b0) ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive(0, 0);
            if (o_rdy === 1'b1) seen = 1'b1;
            else low++;
        end
        checks++;
        if (!seen || low != SETTLE) begin
            errors++;
            $display("[TB] FAIL reset_settle_len got low=%0d seen=%0b want low=%0d", low, seen, SETTLE);
        end
        cnt = 0;
        adj = 0;
        prev = 1'b0;
        for (int i = 0; i < 256; i++) begin
            drive(0, 0);
            if (o_stb === 1'b1) cnt++;
            if (i > 0 && o_stb === prev) adj++;
            prev = o_stb;
        end
        checks++;
        if (cnt != 128 || adj != 0) begin
            errors++;
            $display("[TB] FAIL mode0_rate got strobes=%0d repeats=%0d want 128 and 0", cnt, adj);
        end
    endtask

    task automatic test_mode_switch();
        int drain_len, drain_stb, settle_len, cnt, bad_gap, last;
        bit entered, seen;
        logic entry_stb;
        drain_len = 0; drain_stb = 0; settle_len = 0;
        entered = 1'b0; seen = 1'b0; entry_stb = 1'b0;
        drive(1, 1);
        for (int i = 0; i < 40 && !seen; i++) begin
            drive(0, 0);
            if (o_rdy === 1'b1) seen = 1'b1;
            else if (o_mode === 2'd0) begin
                drain_len++;
                if (o_stb === 1'b1) drain_stb++;
            end else begin
                if (!entered) entry_stb = o_stb;
                entered = 1'b1;
                settle_len++;
            end
        end
        checks++;
        if (!seen || drain_stb != 1 || drain_len < 1 || drain_len > 2) begin
            errors++;
            $display("[TB] FAIL drain_final_strobe got strobes=%0d len=%0d seen=%0b want 1 strobe, len 1..2",
                     drain_stb, drain_len, seen);
        end
        checks++;
        if (settle_len != SETTLE || entry_stb !== 1'b0 || o_mode !== 2'd1) begin
            errors++;
            $display("[TB] FAIL switch_settle got len=%0d entry_stb=%b mode=%0d want len=%0d stb=0 mode=1",
                     settle_len, entry_stb, o_mode, SETTLE);
        end
        cnt = 0; bad_gap = 0; last = -1;
        for (int i = 1; i <= 64; i++) begin
            drive(0, 0);
            if (o_stb === 1'b1) begin
                if (last >= 0 && i - last != 4) bad_gap++;
                last = i;
                cnt++;
            end
        end
        checks++;
        if (cnt != 16 || bad_gap != 0) begin
            errors++;
            $display("[TB] FAIL mode1_cadence got strobes=%0d bad_gaps=%0d want 16 and 0", cnt, bad_gap);
        end
    endtask

    task automatic test_rate_mode2();
        int cnt, bad_gap, last;
        bit seen;
        seen = 1'b0;
        drive(1, 2);
        for (int i = 0; i < 40 && !seen; i++) begin
            drive(0, 0);
            if (o_rdy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || o_mode !== 2'd2) begin
            errors++;
            $display("[TB] FAIL mode2_lock got seen=%0b mode=%0d want 1 and 2", seen, o_mode);
        end
        cnt = 0; bad_gap = 0; last = -1;
        for (int i = 1; i <= 256; i++) begin
            drive(0, 0);
            if (o_stb === 1'b1) begin
                if (last >= 0 && (i - last < 3 || i - last > 4)) bad_gap++;
                last = i;
                cnt++;
            end
        end
        checks++;
        if (cnt != 85 || bad_gap != 0) begin
            errors++;
            $display("[TB] FAIL mode2_rate got strobes=%0d bad_gaps=%0d want 85 and 0", cnt, bad_gap);
        end
    endtask

    task automatic test_invalid_and_same();
        int drops;
        drive(1, 3);
        drive(0, 0);
        checks++;
        if (o_err !== 1'b1 || o_mode !== 2'd2 || o_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL invalid_err_pulse got err=%b mode=%0d rdy=%b want 1, 2, 1", o_err, o_mode, o_rdy);
        end
        drive(0, 0);
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invalid_err_width got err=%b want 0", o_err);
        end
        drive(1, 2);
        drops = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0);
            if (o_rdy !== 1'b1 || o_mode !== 2'd2) drops++;
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("[TB] FAIL same_mode_request got disrupted_cycles=%0d want 0", drops);
        end
    endtask

    task automatic test_settle_requests();
        int low, second;
        bit found, seen;
        // From mode 2 switch to 0, and while settling ask for 1 then 2.
        found = 1'b0;
        drive(1, 0);
        for (int i = 0; i < 20 && !found; i++) begin
            drive(0, 0);
            if (o_mode === 2'd0) found = 1'b1;
        end
        low = 1; second = 0; seen = 1'b0;
        drive(1, 1);
        if (o_rdy === 1'b0) low++;
        drive(1, 2);
        if (o_rdy === 1'b0) low++;
        for (int i = 0; i < 40 && !seen; i++) begin
            drive(0, 0);
            if (o_rdy === 1'b1) seen = 1'b1;
            else begin
                low++;
                if (o_mode === 2'd2) second++;
            end
        end
        checks++;
        if (!found || !seen || low != 2 * SETTLE || second != SETTLE || o_mode !== 2'd2) begin
            errors++;
            $display("[TB] FAIL settle_last_wins got low=%0d second=%0d mode=%0d want %0d, %0d, 2",
                     low, second, o_mode, 2 * SETTLE, SETTLE);
        end
        // From mode 2 switch to 0, and while settling ask for 1 then back to 0.
        found = 1'b0;
        drive(1, 0);
        for (int i = 0; i < 20 && !found; i++) begin
            drive(0, 0);
            if (o_mode === 2'd0) found = 1'b1;
        end
        low = 1; seen = 1'b0;
        drive(1, 1);
        if (o_rdy === 1'b0) low++;
        drive(1, 0);
        if (o_rdy === 1'b0) low++;
        for (int i = 0; i < 40 && !seen; i++) begin
            drive(0, 0);
            if (o_rdy === 1'b1) seen = 1'b1;
            else low++;
        end
        checks++;
        if (!found || !seen || low != SETTLE || o_mode !== 2'd0) begin
            errors++;
            $display("[TB] FAIL settle_back_to_current got low=%0d mode=%0d want %0d and 0", low, o_mode, SETTLE);
        end
        repeat (8) drive(0, 0);
    endtask

    task automatic test_reset_mid_drain();
        int low;
        bit seen, hit;
        seen = 1'b0;
        drive(1, 1);
        for (int i = 0; i < 40 && !seen; i++) begin
            drive(0, 0);
            if (o_rdy === 1'b1) seen = 1'b1;
        end
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            drive(0, 0);
            if (m_state == 1 && m_stb) hit = 1'b1;
        end
        drive(1, 2);
        drive(0, 0);
        checks++;
        if (!seen || !hit || o_rdy !== 1'b0 || o_mode !== 2'd1) begin
            errors++;
            $display("[TB] FAIL drain_entry got rdy=%b mode=%0d seen=%0b hit=%0b want rdy=0 mode=1",
                     o_rdy, o_mode, seen, hit);
        end
        sb_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stb, rdy, err, mode_out} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got stb=%b rdy=%b err=%b mode=%0d want all 0",
                     stb, rdy, err, mode_out);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        low  = (rdy === 1'b0) ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive(0, 0);
            if (o_rdy === 1'b1) seen = 1'b1;
            else low++;
        end
        checks++;
        if (!seen || low != SETTLE || o_mode !== 2'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_settle got low=%0d mode=%0d want %0d and 0", low, o_mode, SETTLE);
        end
        repeat (4) drive(0, 0);
    endtask

    task automatic test_zero_inc();
        int low, cnt;
        bit seen;
        @(posedge clk);
        #1;
        rst_z_n = 1'b1;
        low  = (rdy_z === 1'b0) ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (rdy_z === 1'b1) seen = 1'b1;
            else low++;
        end
        checks++;
        if (!seen || low != SETTLE) begin
            errors++;
            $display("[TB] FAIL zero_inc_lock got low=%0d want %0d", low, SETTLE);
        end
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (stb_z === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("[TB] FAIL zero_inc_silent got strobes=%0d want 0", cnt);
        end
        req_z     = 1'b1;
        mode_z_in = 1'b1;
        @(posedge clk);
        #1;
        req_z = 1'b0;
        checks++;
        if (rdy_z !== 1'b0 || mode_z_out !== 1'b1 || stb_z !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_inc_skip_drain got rdy=%b mode=%b stb=%b want 0, 1, 0",
                     rdy_z, mode_z_out, stb_z);
        end
        low  = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (rdy_z === 1'b1) seen = 1'b1;
            else low++;
        end
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (stb_z === 1'b1) cnt++;
        end
        checks++;
        if (!seen || low != SETTLE || cnt != 32) begin
            errors++;
            $display("[TB] FAIL zero_inc_switch got low=%0d strobes=%0d want %0d and 32", low, cnt, SETTLE);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_z_n   = 1'b0;
        req_z     = 1'b0;
        mode_z_in = 1'b0;
        model_reset();
        test_reset();
        test_mode_switch();
        test_rate_mode2();
        test_invalid_and_same();
        test_settle_requests();
        test_reset_mid_drain();
        test_zero_inc();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_clk_gen.md
Name: vga_clk_gen

Overview:
- Parametrised pixel-rate generator: fractional-N (phase-accumulator) clock-enable generator that derives a one-cycle pixel strobe from a single fabric clock.
- Replaces the fixed-ratio, fixed-frequency pixel clock with NUM_MODES runtime-selectable rates and lock-style ready reporting.
- Glitch-free mode switching: the last pixel period completes, then a settle window runs before the new rate starts.
- Sits between the board clock and the VGA timing generators, which qualify all pixel logic with pix_stb_o.

Parameters:
ACC_W, 16, accumulator width; strobe rate = inc / 2^ACC_W of clk_i.
NUM_MODES, 4, number of selectable rates (>=1).
INC_TABLE, {NUM_MODES*ACC_W bits}, packed increments; mode m in bits [m*ACC_W +: ACC_W]; inc 0 = strobe disabled.
SETTLE_CYCLES, 16, cycles strobe is suppressed after reset or mode change (>=1).
MODE_W, $clog2(NUM_MODES) min 1, mode index width.

Ports:
clk_i  input  1  fabric clock, all logic rising-edge.
rst_ni  input  1  asynchronous active-low reset.
mode_i  input  MODE_W  requested mode, sampled when mode_req_i=1.
mode_req_i  input  1  one-cycle mode change request.
pix_stb_o  output  1  pixel-enable strobe, one cycle wide.
mode_o  output  MODE_W  mode currently applied (updated on SETTLE entry).
ready_o  output  1  high only in RUN; analogous to PLL lock.
err_o  output  1  one-cycle pulse: request with mode_i >= NUM_MODES.

Behaviour:
- Reset (async assert, sync release): acc=0, pix_stb_o=0, ready_o=0, err_o=0, mode_o=0, pending cleared, state=SETTLE, settle counter=SETTLE_CYCLES-1.
- States: SETTLE, RUN, DRAIN.
- SETTLE: acc held 0, pix_stb_o=0, counter decrements each cycle; at counter==0 next state RUN unless pending valid and pending!=mode_o, in which case mode_o<=pending, pending cleared, counter reloaded, stay SETTLE. Reset exit gives exactly SETTLE_CYCLES cycles with ready_o=0.
- RUN: each cycle {carry,acc} <= acc + inc(mode_o) (ACC_W+1-bit sum, modular wrap); pix_stb_o <= carry (registered, 1-cycle latency). ready_o=1.
- Rate: over any 2^ACC_W consecutive RUN cycles, exactly inc strobes; strobe spacing is floor or ceil of 2^ACC_W/inc.
- Valid request in RUN with mode_i==mode_o: ignored, no disruption. With mode_i!=mode_o: store pending; if inc(mode_o)==0, go directly to SETTLE (mode_o<=pending); else DRAIN.
- DRAIN: accumulate as in RUN with old inc; ready_o=0. On the cycle carry=1, the final strobe is still emitted, then SETTLE with mode_o<=pending, counter reloaded. Maximum drain ceil(2^ACC_W/inc) cycles.
- Requests during DRAIN/SETTLE: overwrite pending (last wins). A same-as-mode_o request while in SETTLE is harmless.
- Invalid request (mode_i>=NUM_MODES): err_o pulses the next cycle; state, pending and mode_o are unchanged.
- pix_stb_o is never high in two consecutive cycles unless inc >= 2^(ACC_W-1). It is always 0 in SETTLE.
- Reset asserted mid-DRAIN/SETTLE/RUN: immediate return to reset values; pending is lost.

Test Plan:
1. ACC_W=8, INC_TABLE={85,64,128} (mode0=128), SETTLE_CYCLES=8: release reset -> ready_o=0 for 8 cycles, then 1; pix_stb_o toggles every other cycle; 128 strobes per 256 cycles.
2. Mode0 running, request mode1 (inc 64) -> old period completes with one final strobe, ready_o low through DRAIN + 8 SETTLE cycles, mode_o=1 on SETTLE entry, then strobe every 4th cycle.
3. Mode2 (inc 85) for 256 RUN cycles -> exactly 85 strobes, gaps only 3 or 4 cycles.
4. Request mode 3 with NUM_MODES=3 -> err_o one pulse, mode_o and strobe cadence unchanged. Request current mode -> no ready_o drop.
5. Request mode1 then mode2 during SETTLE -> after settle, a second 8-cycle SETTLE, mode_o=2. Requests 1 then 0 (back to current) -> RUN in mode0 after the single settle.
6. Assert rst_ni mid-DRAIN -> outputs 0 and mode_o=0 asynchronously, full 8-cycle SETTLE after release. Inc=0 mode -> no strobes; a switch away skips DRAIN.
